// File: rtl/miss_refill_ctrl.sv
// Cache miss controller: writes a dirty victim line back word by word, then refills the line from memory.
// Define MISS_REFILL_PERF_CNT_EN to build the saturating miss/writeback performance counters.
module miss_refill_ctrl #(
  parameter int NUM_WAYS   = 4,
  parameter int WAY_BITS   = 2,
  parameter int TAG_BITS   = 22,
  parameter int INDEX_BITS = 6,
  parameter int LINE_WORDS = 8,
  parameter int OFF_BITS   = $clog2(LINE_WORDS)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   miss_valid,
  output logic                                   miss_ready,
  input  logic [INDEX_BITS-1:0]                  miss_index,
  input  logic [TAG_BITS-1:0]                    miss_tag,
  input  logic [WAY_BITS-1:0]                    victim_way,
  input  logic                                   victim_valid,
  input  logic                                   victim_dirty,
  input  logic [TAG_BITS-1:0]                    victim_tag,
  output logic                                   data_rd_en,
  output logic [WAY_BITS-1:0]                    data_rd_way,
  output logic [INDEX_BITS-1:0]                  data_rd_index,
  output logic [OFF_BITS-1:0]                    data_rd_word,
  input  logic [31:0]                            data_rd_data,
  output logic                                   data_wr_en,
  output logic [WAY_BITS-1:0]                    data_wr_way,
  output logic [INDEX_BITS-1:0]                  data_wr_index,
  output logic [OFF_BITS-1:0]                    data_wr_word,
  output logic [31:0]                            data_wr_data,
  output logic                                   meta_wr_en,
  output logic [WAY_BITS-1:0]                    meta_wr_way,
  output logic [INDEX_BITS-1:0]                  meta_wr_index,
  output logic [TAG_BITS-1:0]                    meta_wr_tag,
  output logic                                   meta_wr_valid,
  output logic                                   meta_wr_dirty,
  output logic                                   mem_req_valid,
  input  logic                                   mem_req_ready,
  output logic                                   mem_req_we,
  output logic [TAG_BITS+INDEX_BITS+OFF_BITS-1:0] mem_req_addr,
  output logic [31:0]                            mem_wdata,
  input  logic                                   mem_rsp_valid,
  input  logic [31:0]                            mem_rdata,
  output logic                                   busy,
  output logic                                   refill_done,
  output logic [31:0]                            perf_miss_cnt,
  output logic [31:0]                            perf_wb_cnt
);

  localparam int ADDR_BITS = TAG_BITS + INDEX_BITS + OFF_BITS;
  localparam logic [OFF_BITS-1:0] LAST_WORD = OFF_BITS'(LINE_WORDS - 1);

  if (NUM_WAYS > (1 << WAY_BITS)) begin : g_cfg_check
    $error("miss_refill_ctrl: NUM_WAYS does not fit in WAY_BITS");
  end

  typedef enum logic [2:0] {
    IDLE, WB_READ, WB_CAP, WB_SEND, RF_REQ, RF_WAIT, UPDATE
  } state_t;

  state_t                 state_q, state_d;
  logic [OFF_BITS-1:0]    word_q, word_d;
  logic [INDEX_BITS-1:0]  idx_q, idx_d;
  logic [TAG_BITS-1:0]    tag_q, tag_d;
  logic [TAG_BITS-1:0]    vtag_q, vtag_d;
  logic [WAY_BITS-1:0]    way_q, way_d;
  logic [31:0]            wb_data_q, wb_data_d;

  logic                   miss_ready_q, miss_ready_d;
  logic                   busy_q, busy_d;
  logic                   data_rd_en_q, data_rd_en_d;
  logic [WAY_BITS-1:0]    data_rd_way_q, data_rd_way_d;
  logic [INDEX_BITS-1:0]  data_rd_index_q, data_rd_index_d;
  logic [OFF_BITS-1:0]    data_rd_word_q, data_rd_word_d;
  logic                   mem_req_valid_q, mem_req_valid_d;
  logic                   mem_req_we_q, mem_req_we_d;
  logic [ADDR_BITS-1:0]   mem_req_addr_q, mem_req_addr_d;
  logic [31:0]            mem_wdata_q, mem_wdata_d;
  logic                   meta_wr_en_q, meta_wr_en_d;
  logic [WAY_BITS-1:0]    meta_wr_way_q, meta_wr_way_d;
  logic [INDEX_BITS-1:0]  meta_wr_index_q, meta_wr_index_d;
  logic [TAG_BITS-1:0]    meta_wr_tag_q, meta_wr_tag_d;

  logic accept;
  assign accept = miss_valid && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    idx_d     = idx_q;
    tag_d     = tag_q;
    vtag_d    = vtag_q;
    way_d     = way_q;
    wb_data_d = wb_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d   = miss_index;
          tag_d   = miss_tag;
          vtag_d  = victim_tag;
          way_d   = victim_way;
          word_d  = '0;
          state_d = (victim_valid && victim_dirty) ? WB_READ : RF_REQ;
        end
      end
      WB_READ: state_d = WB_CAP;
      WB_CAP: begin
        wb_data_d = data_rd_data;
        state_d   = WB_SEND;
      end
      WB_SEND: begin
        if (mem_req_ready) begin
          if (word_q == LAST_WORD) begin
            word_d  = '0;
            state_d = RF_REQ;
          end else begin
            word_d  = word_q + OFF_BITS'(1);
            state_d = WB_READ;
          end
        end
      end
      RF_REQ: begin
        if (mem_req_ready) state_d = RF_WAIT;
      end
      RF_WAIT: begin
        if (mem_rsp_valid) begin
          if (word_q == LAST_WORD) begin
            state_d = UPDATE;
          end else begin
            word_d  = word_q + OFF_BITS'(1);
            state_d = RF_REQ;
          end
        end
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered copies line up with the state they belong to.
  always_comb begin
    miss_ready_d    = (state_d == IDLE);
    busy_d          = (state_d != IDLE);
    data_rd_en_d    = (state_d == WB_READ);
    data_rd_way_d   = data_rd_en_d ? way_d  : '0;
    data_rd_index_d = data_rd_en_d ? idx_d  : '0;
    data_rd_word_d  = data_rd_en_d ? word_d : '0;
    mem_req_valid_d = (state_d == WB_SEND) || (state_d == RF_REQ);
    mem_req_we_d    = (state_d == WB_SEND);
    mem_req_addr_d  = '0;
    if (mem_req_we_d) begin
      mem_req_addr_d = {vtag_d, idx_d, word_d};
    end else if (mem_req_valid_d) begin
      mem_req_addr_d = {tag_d, idx_d, word_d};
    end
    mem_wdata_d     = mem_req_we_d ? wb_data_d : '0;
    meta_wr_en_d    = (state_d == UPDATE);
    meta_wr_way_d   = meta_wr_en_d ? way_d : '0;
    meta_wr_index_d = meta_wr_en_d ? idx_d : '0;
    meta_wr_tag_d   = meta_wr_en_d ? tag_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      word_q          <= '0;
      idx_q           <= '0;
      tag_q           <= '0;
      vtag_q          <= '0;
      way_q           <= '0;
      wb_data_q       <= '0;
      miss_ready_q    <= 1'b1;
      busy_q          <= 1'b0;
      data_rd_en_q    <= 1'b0;
      data_rd_way_q   <= '0;
      data_rd_index_q <= '0;
      data_rd_word_q  <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_we_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_wdata_q     <= '0;
      meta_wr_en_q    <= 1'b0;
      meta_wr_way_q   <= '0;
      meta_wr_index_q <= '0;
      meta_wr_tag_q   <= '0;
    end else begin
      state_q         <= state_d;
      word_q          <= word_d;
      idx_q           <= idx_d;
      tag_q           <= tag_d;
      vtag_q          <= vtag_d;
      way_q           <= way_d;
      wb_data_q       <= wb_data_d;
      miss_ready_q    <= miss_ready_d;
      busy_q          <= busy_d;
      data_rd_en_q    <= data_rd_en_d;
      data_rd_way_q   <= data_rd_way_d;
      data_rd_index_q <= data_rd_index_d;
      data_rd_word_q  <= data_rd_word_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_we_q    <= mem_req_we_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      meta_wr_en_q    <= meta_wr_en_d;
      meta_wr_way_q   <= meta_wr_way_d;
      meta_wr_index_q <= meta_wr_index_d;
      meta_wr_tag_q   <= meta_wr_tag_d;
    end
  end

  assign miss_ready    = miss_ready_q;
  assign busy          = busy_q;
  assign data_rd_en    = data_rd_en_q;
  assign data_rd_way   = data_rd_way_q;
  assign data_rd_index = data_rd_index_q;
  assign data_rd_word  = data_rd_word_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_we    = mem_req_we_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign meta_wr_en    = meta_wr_en_q;
  assign meta_wr_way   = meta_wr_way_q;
  assign meta_wr_index = meta_wr_index_q;
  assign meta_wr_tag   = meta_wr_tag_q;
  assign meta_wr_valid = meta_wr_en_q;
  assign meta_wr_dirty = 1'b0;
  assign refill_done   = meta_wr_en_q;

  // Refill data lands in the same cycle as the memory response; reset masks a response for an aborted miss.
  assign data_wr_en    = !rst && (state_q == RF_WAIT) && mem_rsp_valid;
  assign data_wr_way   = data_wr_en ? way_q     : '0;
  assign data_wr_index = data_wr_en ? idx_q     : '0;
  assign data_wr_word  = data_wr_en ? word_q    : '0;
  assign data_wr_data  = data_wr_en ? mem_rdata : '0;

`ifdef MISS_REFILL_PERF_CNT_EN
  logic [31:0] perf_miss_q, perf_miss_d;
  logic [31:0] perf_wb_q, perf_wb_d;

  always_comb begin
    perf_miss_d = perf_miss_q;
    perf_wb_d   = perf_wb_q;
    if (accept && (perf_miss_q != 32'hFFFF_FFFF)) perf_miss_d = perf_miss_q + 32'd1;
    if (accept && victim_valid && victim_dirty && (perf_wb_q != 32'hFFFF_FFFF)) begin
      perf_wb_d = perf_wb_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_miss_q <= '0;
      perf_wb_q   <= '0;
    end else begin
      perf_miss_q <= perf_miss_d;
      perf_wb_q   <= perf_wb_d;
    end
  end

  assign perf_miss_cnt = perf_miss_q;
  assign perf_wb_cnt   = perf_wb_q;
`else
  assign perf_miss_cnt = 32'd0;
  assign perf_wb_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_miss_refill_ctrl.sv
// Directed bench for miss_refill_ctrl: clean and dirty misses, memory stall, ignored inputs and mid-refill reset.
// Memory and data-array responders return address-derived data so every word can be predicted.
module tb_miss_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_valid, miss_ready;
  logic [5:0]  miss_index;
  logic [21:0] miss_tag;
  logic [1:0]  victim_way;
  logic        victim_valid, victim_dirty;
  logic [21:0] victim_tag;
  logic        data_rd_en;
  logic [1:0]  data_rd_way;
  logic [5:0]  data_rd_index;
  logic [2:0]  data_rd_word;
  logic [31:0] data_rd_data = 32'h0;
  logic        data_wr_en;
  logic [1:0]  data_wr_way;
  logic [5:0]  data_wr_index;
  logic [2:0]  data_wr_word;
  logic [31:0] data_wr_data;
  logic        meta_wr_en;
  logic [1:0]  meta_wr_way;
  logic [5:0]  meta_wr_index;
  logic [21:0] meta_wr_tag;
  logic        meta_wr_valid, meta_wr_dirty;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [30:0] mem_req_addr;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy, refill_done;
  logic [31:0] perf_miss_cnt, perf_wb_cnt;

  always #5 clk = ~clk;

  miss_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_ready(miss_ready),
    .miss_index(miss_index), .miss_tag(miss_tag),
    .victim_way(victim_way), .victim_valid(victim_valid),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .data_rd_en(data_rd_en), .data_rd_way(data_rd_way),
    .data_rd_index(data_rd_index), .data_rd_word(data_rd_word),
    .data_rd_data(data_rd_data),
    .data_wr_en(data_wr_en), .data_wr_way(data_wr_way),
    .data_wr_index(data_wr_index), .data_wr_word(data_wr_word),
    .data_wr_data(data_wr_data),
    .meta_wr_en(meta_wr_en), .meta_wr_way(meta_wr_way),
    .meta_wr_index(meta_wr_index), .meta_wr_tag(meta_wr_tag),
    .meta_wr_valid(meta_wr_valid), .meta_wr_dirty(meta_wr_dirty),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata),
    .busy(busy), .refill_done(refill_done),
    .perf_miss_cnt(perf_miss_cnt), .perf_wb_cnt(perf_wb_cnt)
  );

  // Responders: data array returns 0xDA7A000w one cycle after a read; memory returns 0xC0DE0000 ^ addr one cycle after a read request.
  logic        rd_seen = 1'b0;
  logic [2:0]  rd_w = 3'd0;
  logic        rsp_seen = 1'b0;
  logic [30:0] rsp_addr = 31'd0;
  logic        model_rsp = 1'b0;
  logic        stray_rsp = 1'b0;
  assign mem_rsp_valid = model_rsp | stray_rsp;

  always @(negedge clk) begin
    rd_seen  = data_rd_en;
    rd_w     = data_rd_word;
    rsp_seen = mem_req_valid && mem_req_ready && !mem_req_we;
    rsp_addr = mem_req_addr;
  end

  always @(posedge clk) begin
    #1;
    data_rd_data = rd_seen ? (32'hDA7A_0000 | {29'd0, rd_w}) : 32'h0;
    model_rsp    = rsp_seen;
    mem_rdata    = rsp_seen ? (32'hC0DE_0000 ^ {1'b0, rsp_addr}) : 32'h0;
  end

  // Event logs, sampled mid-cycle.
  int          cyc = 0;
  int          acc_cyc = 0, done_cyc = 0, done_cnt = 0, meta_cnt = 0;
  logic [30:0] req_addr_log[$];
  logic        req_we_log[$];
  logic [31:0] req_wd_log[$];
  logic [10:0] rd_log[$];
  logic [10:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic [1:0]  meta_way = 2'd0;
  logic [5:0]  meta_idx = 6'd0;
  logic [21:0] meta_tag = 22'd0;
  logic        meta_valid = 1'b0, meta_dirty = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (miss_valid && miss_ready && !rst) acc_cyc = cyc;
    if (refill_done) begin
      done_cyc = cyc;
      done_cnt++;
    end
    if (meta_wr_en) begin
      meta_cnt++;
      meta_way   = meta_wr_way;
      meta_idx   = meta_wr_index;
      meta_tag   = meta_wr_tag;
      meta_valid = meta_wr_valid;
      meta_dirty = meta_wr_dirty;
    end
    if (mem_req_valid && mem_req_ready) begin
      req_addr_log.push_back(mem_req_addr);
      req_we_log.push_back(mem_req_we);
      req_wd_log.push_back(mem_wdata);
    end
    if (data_rd_en) rd_log.push_back({data_rd_way, data_rd_index, data_rd_word});
    if (data_wr_en) begin
      wr_addr_log.push_back({data_wr_way, data_wr_index, data_wr_word});
      wr_data_log.push_back(data_wr_data);
    end
  end

  int n_compared = 0;
  int n_mismatched = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // sel 0: WB_READ of a word, 1: RF_REQ of a word, other: back to idle. Returns at the negedge of the hit cycle.
  task automatic waitFor(input int sel, input int word, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0:       hit = data_rd_en && (data_rd_word == 3'(word));
        1:       hit = mem_req_valid && !mem_req_we && (mem_req_addr[2:0] == 3'(word));
        default: hit = !busy;
      endcase
    end
    if (!hit) begin
      n_compared++;
      n_mismatched++;
      $error("[TB] FAIL timeout %s observed=no-event expected=event", tag);
    end
  endtask

  // Presents one miss for a single cycle while the controller is idle; returns in cycle 1.
  task automatic applyStimulus(input logic [5:0] idx, input logic [21:0] tag, input logic [1:0] way,
                               input logic vvalid, input logic vdirty, input logic [21:0] vtag);
    @(posedge clk); #1;
    miss_valid   = 1'b1;
    miss_index   = idx;
    miss_tag     = tag;
    victim_way   = way;
    victim_valid = vvalid;
    victim_dirty = vdirty;
    victim_tag   = vtag;
    @(posedge clk); #1;
    miss_valid   = 1'b0;
  endtask

  task automatic checkReqs(input string p, input int base, input logic we,
                           input logic [21:0] tag, input logic [5:0] idx);
    for (int w = 0; w < 8; w++) begin
      checkOutput($sformatf("%s req%0d addr", p, w), req_addr_log[base+w], {tag, idx, 3'(w)});
      checkOutput($sformatf("%s req%0d we", p, w), req_we_log[base+w], we);
      if (we) checkOutput($sformatf("%s req%0d wdata", p, w), req_wd_log[base+w], 32'hDA7A_0000 | w);
    end
  endtask

  task automatic checkWrites(input string p, input int base, input logic [1:0] way,
                             input logic [5:0] idx, input logic [21:0] tag);
    for (int w = 0; w < 8; w++) begin
      checkOutput($sformatf("%s wr%0d addr", p, w), wr_addr_log[base+w], {way, idx, 3'(w)});
      checkOutput($sformatf("%s wr%0d data", p, w), wr_data_log[base+w],
                  32'hC0DE_0000 ^ {1'b0, tag, idx, 3'(w)});
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  int rq0, wr0, rd0, mc0, dc0, dup;
  logic [31:0] exp_miss, exp_wb;

  initial begin
    rst = 1'b1;
    miss_valid = 1'b0; miss_index = '0; miss_tag = '0; victim_way = '0;
    victim_valid = 1'b0; victim_dirty = 1'b0; victim_tag = '0;
    mem_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset miss_ready", miss_ready, 1);
    checkOutput("reset strobes", {busy, data_rd_en, data_wr_en, meta_wr_en, mem_req_valid, refill_done}, 0);
    checkOutput("reset addr", mem_req_addr, 0);
    checkOutput("reset perf", {perf_miss_cnt, perf_wb_cnt}, 0);
    rst = 1'b0;

    // Clean miss.
    rq0 = req_addr_log.size(); wr0 = wr_addr_log.size(); rd0 = rd_log.size(); mc0 = meta_cnt; dc0 = done_cnt;
    applyStimulus(6'd5, 22'h12345, 2'd2, 1'b1, 1'b0, 22'h0DEAD);
    waitFor(2, 0, "t1 idle");
    checkOutput("t1 latency", done_cyc - acc_cyc, 17);
    checkOutput("t1 req count", req_addr_log.size() - rq0, 8);
    checkReqs("t1", rq0, 1'b0, 22'h12345, 6'd5);
    checkOutput("t1 wr count", wr_addr_log.size() - wr0, 8);
    checkWrites("t1", wr0, 2'd2, 6'd5, 22'h12345);
    checkOutput("t1 rd count", rd_log.size() - rd0, 0);
    checkOutput("t1 meta count", meta_cnt - mc0, 1);
    checkOutput("t1 meta", {meta_way, meta_idx, meta_tag, meta_valid, meta_dirty}, {2'd2, 6'd5, 22'h12345, 1'b1, 1'b0});
    checkOutput("t1 done count", done_cnt - dc0, 1);

    // Dirty victim, with a stray response injected during WB_SEND of word 2.
    rq0 = req_addr_log.size(); wr0 = wr_addr_log.size(); rd0 = rd_log.size(); dc0 = done_cnt;
    applyStimulus(6'd9, 22'h00777, 2'd1, 1'b1, 1'b1, 22'h00ABC);
    waitFor(0, 2, "t2 wb_read2");
    @(posedge clk); #1;
    @(posedge clk); #1;
    stray_rsp = 1'b1;
    #1;
    checkOutput("t2 in wb_send", {mem_req_valid, mem_req_we}, 2'b11);
    checkOutput("t2 stray wr_en", data_wr_en, 0);
    @(posedge clk); #1;
    stray_rsp = 1'b0;
    waitFor(2, 0, "t2 idle");
    checkOutput("t2 latency", done_cyc - acc_cyc, 41);
    checkOutput("t2 req count", req_addr_log.size() - rq0, 16);
    checkReqs("t2 wb", rq0, 1'b1, 22'h00ABC, 6'd9);
    checkReqs("t2 rf", rq0 + 8, 1'b0, 22'h00777, 6'd9);
    checkOutput("t2 rd count", rd_log.size() - rd0, 8);
    for (int w = 0; w < 8; w++) checkOutput($sformatf("t2 rd%0d", w), rd_log[rd0+w], {2'd1, 6'd9, 3'(w)});
    checkOutput("t2 wr count", wr_addr_log.size() - wr0, 8);
    checkWrites("t2", wr0, 2'd1, 6'd9, 22'h00777);
    checkOutput("t2 meta", {meta_way, meta_idx, meta_tag, meta_valid, meta_dirty}, {2'd1, 6'd9, 22'h00777, 1'b1, 1'b0});
    checkOutput("t2 done count", done_cnt - dc0, 1);

    // Invalid-but-dirty victim refills only; a miss pulsed during RF_WAIT must be ignored.
    rq0 = req_addr_log.size(); wr0 = wr_addr_log.size(); dc0 = done_cnt;
    applyStimulus(6'd63, 22'h3FFFFF, 2'd0, 1'b0, 1'b1, 22'h11111);
    waitFor(1, 3, "t3 rf_req3");
    @(posedge clk); #1;
    miss_valid = 1'b1; miss_index = 6'd7; miss_tag = 22'h00001;
    victim_valid = 1'b1; victim_dirty = 1'b1;
    checkOutput("t3 miss_ready busy", miss_ready, 0);
    @(posedge clk); #1;
    miss_valid = 1'b0;
    waitFor(2, 0, "t3 idle");
    checkOutput("t3 latency", done_cyc - acc_cyc, 17);
    checkOutput("t3 req count", req_addr_log.size() - rq0, 8);
    checkReqs("t3", rq0, 1'b0, 22'h3FFFFF, 6'd63);
    checkOutput("t3 wr count", wr_addr_log.size() - wr0, 8);
    checkWrites("t3", wr0, 2'd0, 6'd63, 22'h3FFFFF);
    checkOutput("t3 meta tag", {meta_idx, meta_tag}, {6'd63, 22'h3FFFFF});
    checkOutput("t3 done count", done_cnt - dc0, 1);
`ifdef MISS_REFILL_PERF_CNT_EN
    exp_miss = 32'd3; exp_wb = 32'd1;
`else
    exp_miss = 32'd0; exp_wb = 32'd0;
`endif
    checkOutput("perf miss after 3", perf_miss_cnt, exp_miss);
    checkOutput("perf wb after 3", perf_wb_cnt, exp_wb);

    // Dirty victim with memory stalling the word-4 writeback for three cycles.
    rq0 = req_addr_log.size(); dc0 = done_cnt;
    applyStimulus(6'd3, 22'h00055, 2'd3, 1'b1, 1'b1, 22'h2AAAA);
    waitFor(0, 4, "t4 wb_read4");
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("t4 stall%0d valid", k), {mem_req_valid, mem_req_we}, 2'b11);
      checkOutput($sformatf("t4 stall%0d addr", k), mem_req_addr, {22'h2AAAA, 6'd3, 3'd4});
      checkOutput($sformatf("t4 stall%0d wdata", k), mem_wdata, 32'hDA7A_0004);
    end
    mem_req_ready = 1'b1;
    waitFor(2, 0, "t4 idle");
    checkOutput("t4 latency", done_cyc - acc_cyc, 44);
    checkOutput("t4 req count", req_addr_log.size() - rq0, 16);
    checkReqs("t4 wb", rq0, 1'b1, 22'h2AAAA, 6'd3);
    dup = 0;
    for (int i = rq0; i < req_addr_log.size(); i++) begin
      if (req_we_log[i] && (req_addr_log[i][2:0] == 3'd4)) dup++;
    end
    checkOutput("t4 word4 requests", dup, 1);
    checkOutput("t4 done count", done_cnt - dc0, 1);

    // Reset during RF_WAIT of word 3 aborts the miss.
    wr0 = wr_addr_log.size(); mc0 = meta_cnt; dc0 = done_cnt;
    applyStimulus(6'd10, 22'h00100, 2'd1, 1'b1, 1'b0, 22'h00200);
    waitFor(1, 3, "t5 rf_req3");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("t5 wr_en under rst", data_wr_en, 0);
    @(posedge clk); #1;
    checkOutput("t5 miss_ready", miss_ready, 1);
    checkOutput("t5 strobes", {busy, mem_req_valid, data_rd_en, meta_wr_en, refill_done}, 0);
    checkOutput("t5 addr", mem_req_addr, 0);
    checkOutput("t5 perf", {perf_miss_cnt, perf_wb_cnt}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t5 idle after", {miss_ready, busy}, 2'b10);
    checkOutput("t5 wr count", wr_addr_log.size() - wr0, 3);
    checkOutput("t5 no meta", meta_cnt - mc0, 0);
    checkOutput("t5 no done", done_cnt - dc0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
